// File: rtl/haraka_pkg.sv
// Shared Haraka-S definitions: block widths, sponge FSM encoding, padding bytes.
package haraka_pkg;

    localparam int RATE_BITS  = 256;
    localparam int STATE_BITS = 512;

    // Padding bytes shared with the byte deserializer
    localparam logic [7:0] PAD_BEGINNING = 8'h1f;
    localparam logic [7:0] PAD_ENDING    = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PERM_A,
        SQUEEZE,
        PERM_S,
        FINISH
    } sponge_state_t;

endpackage

// File: rtl/haraka_s_sponge_ctrl.sv
// Haraka-S sponge controller: absorbs rate blocks into the sponge state,
// drives the external permutation core and squeezes a fixed number of blocks.
module haraka_s_sponge_ctrl #(
    parameter int RATE_BITS      = haraka_pkg::RATE_BITS,
    parameter int STATE_BITS     = haraka_pkg::STATE_BITS,
    parameter int SQUEEZE_BLOCKS = 2
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [RATE_BITS-1:0]  in_block,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [STATE_BITS-1:0] perm_state_out,
    output logic                  perm_start,
    input  logic [STATE_BITS-1:0] perm_state_in,
    input  logic                  perm_done,
    output logic [RATE_BITS-1:0]  out_block,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    import haraka_pkg::*;

    localparam int CNT_W = $clog2(SQUEEZE_BLOCKS + 1);
    localparam logic [CNT_W-1:0] SQ_LAST = CNT_W'(SQUEEZE_BLOCKS);

    sponge_state_t           fsm_q,     fsm_d;
    logic [STATE_BITS-1:0]   state_q,   state_d;
    logic                    last_q,    last_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic                    start_q,   start_d;
    logic                    overrun_q, overrun_d;
    logic [CNT_W-1:0]        cnt_inc;

    // Outputs decoded straight from registered state
    assign in_ready       = (fsm_q == IDLE) || (fsm_q == ABSORB);
    assign out_valid      = (fsm_q == SQUEEZE);
    assign busy           = (fsm_q != IDLE);
    assign done           = (fsm_q == FINISH);
    assign perm_start     = start_q;
    assign overrun        = overrun_q;
    assign perm_state_out = state_q;
    assign out_block      = state_q[RATE_BITS-1:0];

    // Next-state logic: absorb XOR, permutation sequencing, squeeze counting
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        overrun_d = overrun_q;
        cnt_inc   = cnt_q + CNT_W'(1);

        // A block offered while we cannot take it is dropped and flagged
        if (in_valid && !in_ready) begin
            overrun_d = 1'b1;
        end

        unique case (fsm_q)
            IDLE, ABSORB: begin
                if (in_valid) begin
                    state_d[RATE_BITS-1:0] = state_q[RATE_BITS-1:0] ^ in_block;
                    last_d  = in_last;
                    start_d = 1'b1;
                    fsm_d   = PERM_A;
                end
            end
            PERM_A: begin
                if (perm_done) begin
                    state_d = perm_state_in;
                    fsm_d   = last_q ? SQUEEZE : ABSORB;
                end
            end
            SQUEEZE: begin
                if (out_ready) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == SQ_LAST) begin
                        fsm_d = FINISH;
                    end else begin
                        start_d = 1'b1;
                        fsm_d   = PERM_S;
                    end
                end
            end
            PERM_S: begin
                if (perm_done) begin
                    state_d = perm_state_in;
                    fsm_d   = SQUEEZE;
                end
            end
            FINISH: begin
                // Wipe the sponge so the next message starts from zero
                state_d = '0;
                cnt_d   = '0;
                last_d  = 1'b0;
                fsm_d   = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State registers; clear overrides every other event in the same cycle
    always_ff @(posedge clk) begin
        if (clear) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_haraka_s_sponge_ctrl.sv
// Bench for haraka_s_sponge_ctrl: random messages against a plain sponge model,
// with a 4-cycle permutation core model and directed corner cases.
module tb_haraka_s_sponge_ctrl;

    localparam int RB  = 256;
    localparam int SB  = 512;
    localparam int NSQ = 2;

    logic          clk = 1'b0;
    logic          clear;
    logic [RB-1:0] in_block;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [SB-1:0] perm_state_out;
    logic          perm_start;
    logic [SB-1:0] perm_state_in;
    logic          perm_done;
    logic [RB-1:0] out_block;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          overrun;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Permutation core model and manual injection of stray results
    logic          core_en   = 1'b1;
    int            core_cnt  = 0;
    logic          core_done = 1'b0;
    logic [SB-1:0] core_res  = '0;
    logic          man_done;
    logic [SB-1:0] man_state;
    int            start_pulses  = 0;
    int            double_starts = 0;
    logic          start_prev    = 1'b0;

    assign perm_done     = core_done | man_done;
    assign perm_state_in = man_done ? man_state : core_res;

    haraka_s_sponge_ctrl #(
        .RATE_BITS      (RB),
        .STATE_BITS     (SB),
        .SQUEEZE_BLOCKS (NSQ)
    ) dut (
        .clk            (clk),
        .clear          (clear),
        .in_block       (in_block),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .perm_state_out (perm_state_out),
        .perm_start     (perm_start),
        .perm_state_in  (perm_state_in),
        .perm_done      (perm_done),
        .out_block      (out_block),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Stand-in permutation: any fixed bijective-looking mix will do
    function automatic logic [SB-1:0] perm_f(input logic [SB-1:0] s);
        return ({s[446:0], s[511:447]} ^ {s[255:0], s[511:256]}) + {16{32'h9E3779B9}};
    endfunction

    function automatic logic [RB-1:0] rand256();
        logic [RB-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Core answers perm_done four edges after sampling perm_start
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        core_done <= 1'b0;
        if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_done <= 1'b1;
        end
        if (perm_start && core_en) begin
            core_cnt <= 3;
            core_res <= perm_f(perm_state_out);
        end
        if (perm_start) start_pulses <= start_pulses + 1;
        if (perm_start && start_prev) double_starts <= double_starts + 1;
        start_prev <= perm_start;
    end

    task automatic check_eq(input string tag, input logic [SB-1:0] act, input logic [SB-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One full message: absorb nblk random blocks, squeeze NSQ blocks with backpressure
    task automatic run_msg(input int nblk, input int bp, input bit inj_ovr,
                           input bit fin_ovr, input bit fixed_blk);
        logic [SB-1:0] s;
        logic [RB-1:0] blk;
        logic [RB-1:0] held;
        int n;
        int sp0;
        int t_ref;
        s   = '0;
        sp0 = start_pulses;
        t_ref = cyc;
        for (int b = 0; b < nblk; b++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n = 0;
            while (!in_ready && n < 100) begin @(negedge clk); n++; end
            check_eq("in_ready_wait", SB'(in_ready), SB'(1'b1));
            blk      = fixed_blk ? {32{8'h11}} : rand256();
            in_block = blk;
            in_valid = 1'b1;
            in_last  = (b == nblk - 1);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            t_ref    = cyc;
            s[RB-1:0] = s[RB-1:0] ^ blk;
            check_eq("absorb_state", perm_state_out, s);
            check_eq("absorb_start", SB'(perm_start), SB'(1'b1));
            if (inj_ovr && b == 0) begin
                in_block = rand256();
                in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
                check_eq("overrun_set", SB'(overrun), SB'(1'b1));
                check_eq("overrun_state_kept", perm_state_out, s);
            end
            s = perm_f(s);
        end
        for (int k = 0; k < NSQ; k++) begin
            n = 0;
            while (!out_valid && n < 100) begin @(negedge clk); n++; end
            check_eq("out_valid_wait", SB'(out_valid), SB'(1'b1));
            check_eq("out_latency", SB'(cyc - t_ref), SB'(5));
            check_eq("out_block", SB'(out_block), SB'(s[RB-1:0]));
            held = out_block;
            for (int c = 0; c < bp; c++) begin
                @(negedge clk);
                check_eq("bp_out_valid", SB'(out_valid), SB'(1'b1));
                check_eq("bp_out_block", SB'(out_block), SB'(held));
                check_eq("bp_no_start", SB'(perm_start), SB'(1'b0));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            t_ref     = cyc;
            if (k < NSQ - 1) begin
                check_eq("squeeze_start", SB'(perm_start), SB'(1'b1));
                check_eq("squeeze_state", perm_state_out, s);
                s = perm_f(s);
            end
        end
        check_eq("done_pulse", SB'(done), SB'(1'b1));
        if (fin_ovr) in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("idle_done", SB'(done), SB'(1'b0));
        check_eq("idle_busy", SB'(busy), SB'(1'b0));
        check_eq("idle_in_ready", SB'(in_ready), SB'(1'b1));
        check_eq("idle_state_zero", perm_state_out, SB'(0));
        check_eq("idle_no_start", SB'(perm_start), SB'(1'b0));
        if (fin_ovr) check_eq("finish_overrun", SB'(overrun), SB'(1'b1));
        check_eq("start_count", SB'(start_pulses - sp0), SB'(nblk + NSQ - 1));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int n;
        clear     = 1'b1;
        in_block  = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        man_done  = 1'b0;
        man_state = '0;
        repeat (2) @(negedge clk);
        clear = 1'b0;

        check_eq("rst_in_ready", SB'(in_ready), SB'(1'b1));
        check_eq("rst_busy", SB'(busy), SB'(1'b0));
        check_eq("rst_out_valid", SB'(out_valid), SB'(1'b0));
        check_eq("rst_done", SB'(done), SB'(1'b0));
        check_eq("rst_overrun", SB'(overrun), SB'(1'b0));
        check_eq("rst_perm_start", SB'(perm_start), SB'(1'b0));
        check_eq("rst_state", perm_state_out, SB'(0));

        run_msg(1, 0, 1'b0, 1'b0, 1'b1);
        run_msg(3, 2, 1'b0, 1'b0, 1'b0);
        run_msg(2, 10, 1'b0, 1'b0, 1'b0);
        run_msg(2, 1, 1'b1, 1'b0, 1'b0);
        run_msg(1, 0, 1'b0, 1'b0, 1'b0);
        check_eq("overrun_sticky", SB'(overrun), SB'(1'b1));

        do_clear();
        check_eq("clear_overrun", SB'(overrun), SB'(1'b0));
        run_msg(1, 0, 1'b0, 1'b1, 1'b0);

        for (int m = 0; m < 6; m++) begin
            run_msg($urandom_range(1, 4), $urandom_range(0, 5), 1'b0, 1'b0, 1'b0);
        end

        // clear in PERM_S colliding with perm_done
        do_clear();
        in_block = rand256();
        in_valid = 1'b1;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        check_eq("cl_out_valid_wait", SB'(out_valid), SB'(1'b1));
        core_en   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("cl_in_perm_s", SB'({busy, out_valid, in_ready}), SB'(3'b100));
        @(negedge clk);
        clear     = 1'b1;
        man_done  = 1'b1;
        man_state = {rand256(), rand256()};
        @(negedge clk);
        clear    = 1'b0;
        man_done = 1'b0;
        check_eq("cl_busy", SB'(busy), SB'(1'b0));
        check_eq("cl_in_ready", SB'(in_ready), SB'(1'b1));
        check_eq("cl_out_valid", SB'(out_valid), SB'(1'b0));
        check_eq("cl_state", perm_state_out, SB'(0));
        @(negedge clk);
        man_done  = 1'b1;
        man_state = {rand256(), rand256()};
        @(negedge clk);
        man_done = 1'b0;
        check_eq("late_done_state", perm_state_out, SB'(0));
        check_eq("late_done_busy", SB'(busy), SB'(1'b0));
        check_eq("late_done_out_valid", SB'(out_valid), SB'(1'b0));
        core_en = 1'b1;

        // Stray perm_done and out_ready while idle
        man_done  = 1'b1;
        man_state = {rand256(), rand256()};
        out_ready = 1'b1;
        @(negedge clk);
        man_done  = 1'b0;
        out_ready = 1'b0;
        check_eq("stray_state", perm_state_out, SB'(0));
        check_eq("stray_busy", SB'(busy), SB'(1'b0));
        check_eq("stray_done", SB'(done), SB'(1'b0));
        check_eq("stray_out_valid", SB'(out_valid), SB'(1'b0));

        run_msg(2, 0, 1'b0, 1'b0, 1'b0);
        check_eq("no_back_to_back_start", SB'(double_starts), SB'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
